// File: rtl/adder_pipe_nbits_if.sv
// Operand/result bus for adder_pipe_nbits.
// Producer side: in_valid, a, b, sub and c_in go to the adder, and in_ready comes back.
// Consumer side: out_valid and the result with its flags go to the consumer, and out_ready comes back.
// The master modport is the side that supplies operands and consumes results.
// The slave modport is the adder itself.
interface adder_pipe_nbits_if #(
    parameter int NUMBER_OF_BITS = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [NUMBER_OF_BITS-1:0] a;
    logic [NUMBER_OF_BITS-1:0] b;
    logic                      sub;
    logic                      c_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUMBER_OF_BITS-1:0] s_out;
    logic                      c_out;
    logic                      overflow;
    logic                      zero;

    modport master (
        output in_valid, a, b, sub, c_in, out_ready,
        input  in_ready, out_valid, s_out, c_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, sub, c_in, out_ready,
        output in_ready, out_valid, s_out, c_out, overflow, zero
    );
endinterface

// File: rtl/adder_pipe_nbits.sv
// Pipelined add/subtract unit. NUMBER_OF_BITS is split into STAGE_BITS chunks.
// Each stage adds one chunk, so the carry chain per cycle is one chunk long.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - operand/result handshake (adder_pipe_nbits_if.slave)
// The whole pipe stalls when the result is valid and not taken.
// When stalled, in_ready is low.
module adder_pipe_nbits #(
    parameter int NUMBER_OF_BITS = 32,
    parameter int STAGE_BITS     = 8
) (
    input logic               clk,
    input logic               rst,
    adder_pipe_nbits_if.slave bus
);
    localparam int N      = NUMBER_OF_BITS;
    localparam int SB     = STAGE_BITS;
    localparam int STAGES = N / SB;
    localparam int LAST   = STAGES - 1;

    typedef logic [N-1:0] word_t;

    word_t             a_q [STAGES];
    word_t             a_d [STAGES];
    word_t             b_q [STAGES];
    word_t             b_d [STAGES];
    word_t             s_q [STAGES];
    word_t             s_d [STAGES];
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] v_q, v_d;
    logic              ov_q, ov_d;
    logic              zero_q, zero_d;
    logic              adv;
    logic [SB+1:0]     r_chunk [STAGES];

    // The result is packed as {carry out, carry into chunk MSB, sum}.
    // The carry into the MSB is recovered as x ^ y ^ sum at the top bit.
    function automatic logic [SB+1:0] add_chunk(input logic [SB-1:0] x,
                                                input logic [SB-1:0] y,
                                                input logic          ci);
        logic [SB:0] sum;
        sum = {1'b0, x} + {1'b0, y} + {{SB{1'b0}}, ci};
        return {sum[SB], x[SB-1] ^ y[SB-1] ^ sum[SB-1], sum[SB-1:0]};
    endfunction

    always_comb begin
        adv = !v_q[LAST] || bus.out_ready;

        // The add/sub mode is resolved here, so later stages only ever add.
        a_d[0]     = bus.a;
        b_d[0]     = bus.sub ? ~bus.b : bus.b;
        r_chunk[0] = add_chunk(bus.a[SB-1:0], b_d[0][SB-1:0], bus.sub | bus.c_in);
        s_d[0]          = '0;
        s_d[0][SB-1:0]  = r_chunk[0][SB-1:0];
        c_d[0]          = r_chunk[0][SB+1];
        v_d[0]          = bus.in_valid;

        for (int k = 1; k < STAGES; k++) begin
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            r_chunk[k] = add_chunk(a_q[k-1][k*SB +: SB], b_q[k-1][k*SB +: SB], c_q[k-1]);
            s_d[k]               = s_q[k-1];
            s_d[k][k*SB +: SB]   = r_chunk[k][SB-1:0];
            c_d[k]               = r_chunk[k][SB+1];
            v_d[k]               = v_q[k-1];
        end

        ov_d   = r_chunk[LAST][SB+1] ^ r_chunk[LAST][SB];
        zero_d = (s_d[LAST] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q    <= '0;
            v_q    <= '0;
            ov_q   <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            c_q    <= c_d;
            v_q    <= v_d;
            ov_q   <= ov_d;
            zero_q <= zero_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = v_q[LAST];
    assign bus.s_out     = s_q[LAST];
    assign bus.c_out     = c_q[LAST];
    assign bus.overflow  = ov_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_adder_pipe_nbits.sv
// Bench for adder_pipe_nbits.
// Two instances are driven from the same operand and ready signals:
//   u_dut0 - 4 stages of 8 bits
//   u_dut1 - a single 32-bit stage
module tb_adder_pipe_nbits;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, sub, c_in, out_ready;
    logic [31:0] a, b;

    adder_pipe_nbits_if #(.NUMBER_OF_BITS(32)) bus0 ();
    adder_pipe_nbits_if #(.NUMBER_OF_BITS(32)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.a         = a;
    assign bus0.b         = b;
    assign bus0.sub       = sub;
    assign bus0.c_in      = c_in;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.a         = a;
    assign bus1.b         = b;
    assign bus1.sub       = sub;
    assign bus1.c_in      = c_in;
    assign bus1.out_ready = out_ready;

    adder_pipe_nbits #(.NUMBER_OF_BITS(32), .STAGE_BITS(8)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    adder_pipe_nbits #(.NUMBER_OF_BITS(32), .STAGE_BITS(32)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] s;
        logic        c;
        logic        ov;
        logic        z;
    } res_t;

    // Each model pipe holds what each instance's output must show after 1..STAGES advances.
    res_t m0 [4];
    res_t m1 [1];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // Full-width result from two's-complement arithmetic.
    // Signed overflow is when both addend signs agree and the sum sign differs.
    function automatic res_t model_op(input logic [31:0] x, input logic [31:0] y,
                                      input logic s, input logic ci);
        res_t        r;
        logic [31:0] yy;
        logic [32:0] wide;
        yy     = s ? ~y : y;
        wide   = {1'b0, x} + {1'b0, yy} + {32'd0, (s ? 1'b1 : ci)};
        r.v    = 1'b1;
        r.s    = wide[31:0];
        r.c    = wide[32];
        r.ov   = (x[31] == yy[31]) && (wide[31] != x[31]);
        r.z    = (wide[31:0] == 32'd0);
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m0[i] = '0;
            m1[0] = '0;
        end else begin
            if (!m0[3].v || out_ready) begin
                for (int i = 3; i > 0; i--) m0[i] = m0[i-1];
                m0[0] = in_valid ? model_op(a, b, sub, c_in) : '0;
            end
            if (!m1[0].v || out_ready)
                m1[0] = in_valid ? model_op(a, b, sub, c_in) : '0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("u0.in_ready",  {31'd0, bus0.in_ready},  {31'd0, !m0[3].v || out_ready});
            chk("u0.out_valid", {31'd0, bus0.out_valid}, {31'd0, m0[3].v});
            if (m0[3].v) begin
                chk("u0.s_out",    bus0.s_out,              m0[3].s);
                chk("u0.c_out",    {31'd0, bus0.c_out},     {31'd0, m0[3].c});
                chk("u0.overflow", {31'd0, bus0.overflow},  {31'd0, m0[3].ov});
                chk("u0.zero",     {31'd0, bus0.zero},      {31'd0, m0[3].z});
            end
            chk("u1.in_ready",  {31'd0, bus1.in_ready},  {31'd0, !m1[0].v || out_ready});
            chk("u1.out_valid", {31'd0, bus1.out_valid}, {31'd0, m1[0].v});
            if (m1[0].v) begin
                chk("u1.s_out",    bus1.s_out,              m1[0].s);
                chk("u1.c_out",    {31'd0, bus1.c_out},     {31'd0, m1[0].c});
                chk("u1.overflow", {31'd0, bus1.overflow},  {31'd0, m1[0].ov});
                chk("u1.zero",     {31'd0, bus1.zero},      {31'd0, m1[0].z});
            end
        end
    end

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // One operation into an idle pipe.
    // Checks the latency of both instances and the literal result.
    task automatic directed(input logic [31:0] xa, input logic [31:0] xb,
                            input logic xs, input logic xc,
                            input logic [31:0] es, input logic ec,
                            input logic eov, input logic ez);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = xa; b = xb; sub = xs; c_in = xc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        chk("lit.u1.out_valid", {31'd0, bus1.out_valid}, 32'd1);
        chk("lit.u1.s_out",     bus1.s_out, es);
        chk("lit.u1.flags",     {29'd0, bus1.c_out, bus1.overflow, bus1.zero}, {29'd0, ec, eov, ez});
        while (bus0.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lit.u0.latency", lat, 32'd4);
        chk("lit.u0.s_out",   bus0.s_out, es);
        chk("lit.u0.flags",   {29'd0, bus0.c_out, bus0.overflow, bus0.zero}, {29'd0, ec, eov, ez});
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seen, expm;
        logic [31:0] hold_s;
        logic [2:0]  hold_f;
        int          t, cnt;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        chk("rst.u0.out_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("rst.u0.s_out",     bus0.s_out, 32'd0);
        chk("rst.u0.flags",     {29'd0, bus0.c_out, bus0.overflow, bus0.zero}, 32'd0);
        chk("rst.u0.in_ready",  {31'd0, bus0.in_ready}, 32'd1);
        chk("rst.u1.out_valid", {31'd0, bus1.out_valid}, 32'd0);
        chk("rst.u1.s_out",     bus1.s_out, 32'd0);

        directed(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        directed(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        directed(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        directed(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        // Streaming: six back-to-back operations with alternating add and subtract.
        seen = '0;
        expm = '0;
        for (int i = 4; i <= 9; i++) expm[i] = 1'b1;
        t = 1;
        for (int j = 0; j < 6; j++) begin
            in_valid = 1'b1;
            a = $urandom; b = $urandom; sub = j[0]; c_in = 1'($urandom);
            @(posedge clk); #1;
            seen[t] = bus0.out_valid;
            t++;
        end
        in_valid = 1'b0;
        while (t < 14) begin
            @(posedge clk); #1;
            seen[t] = bus0.out_valid;
            t++;
        end
        chk("stream.valid_pattern", {16'd0, seen}, {16'd0, expm});
        drain();

        // Backpressure: stall a valid result for three cycles while a new operand waits.
        in_valid = 1'b1;
        a = $urandom; b = $urandom; sub = 1'b0; c_in = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (bus0.out_valid !== 1'b1 && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("bp.result_arrived", {31'd0, bus0.out_valid}, 32'd1);
        out_ready = 1'b0;
        hold_s = bus0.s_out;
        hold_f = {bus0.c_out, bus0.overflow, bus0.zero};
        in_valid = 1'b1;
        a = $urandom; b = $urandom; sub = 1'b1; c_in = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp.in_ready",  {31'd0, bus0.in_ready}, 32'd0);
            chk("bp.out_valid", {31'd0, bus0.out_valid}, 32'd1);
            chk("bp.s_stable",  bus0.s_out, hold_s);
            chk("bp.f_stable",  {29'd0, bus0.c_out, bus0.overflow, bus0.zero}, {29'd0, hold_f});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset with two operations in flight.
        // The operand presented during reset must be dropped.
        for (int j = 0; j < 2; j++) begin
            in_valid = 1'b1;
            a = $urandom; b = $urandom; sub = j[0]; c_in = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        a = $urandom;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (6) begin
            chk("rstmid.u0.out_valid", {31'd0, bus0.out_valid}, 32'd0);
            chk("rstmid.u1.out_valid", {31'd0, bus1.out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        directed(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h0123_4567, 1'b1, 1'b0, 1'b0);

        // Random traffic with random backpressure and occasional resets.
        for (int j = 0; j < 500; j++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            case ($urandom_range(4))
                0:       a = 32'hFFFF_FFFF;
                1:       a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            b    = ($urandom_range(5) == 0) ? 32'd0 : $urandom;
            sub  = 1'($urandom);
            c_in = 1'($urandom);
            rst  = ($urandom_range(63) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
